// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side transmit and receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

  localparam int INHIBIT_CYCLES_DEF = 6000;
  localparam int TIMEOUT_CYCLES_DEF = 750000;
  localparam int FILTER_CYCLES_DEF  = 8;

  // Last device clock fall of the host-driven part of the frame (stop bit).
  localparam logic [3:0] STOP_FALL = 4'd10;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Conditions the raw PS2_CLK/PS2_DAT levels: 2-FF synchronizers, a stability
// filter on the clock and a one-cycle strobe on each filtered falling edge.
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_ps2_clk,
  input  logic i_ps2_dat,
  output logic o_clk_filt,
  output logic o_dat_sync,
  output logic o_fall
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] FILT_LAST = CW'(FILTER_CYCLES - 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_clk_filt;
  logic          r_clk_filt_d;
  logic [CW-1:0] r_filt_cnt;

  // Lines idle high, so reset to 1 to avoid a spurious fall after reset.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_clk_sync   <= 2'b11;
      r_dat_sync   <= 2'b11;
      r_clk_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
      r_filt_cnt   <= '0;
    end else begin
      r_clk_sync   <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync   <= {r_dat_sync[0], i_ps2_dat};
      r_clk_filt_d <= r_clk_filt;
      if (r_clk_sync[1] == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_LAST) begin
        r_clk_filt <= r_clk_sync[1];
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + CW'(1);
      end
    end
  end

  assign o_clk_filt = r_clk_filt;
  assign o_dat_sync = r_dat_sync[1];
  assign o_fall     = r_clk_filt_d & ~r_clk_filt;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clock out
// data/parity/stop on device clock falls, then check the device ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int FILTER_CYCLES  = FILTER_CYCLES_DEF
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_e    r_state, w_state_next;
  logic [7:0]    r_data, w_data_next;
  logic          r_parity, w_parity_next;
  logic [3:0]    r_bit_cnt, w_bit_cnt_next;
  logic [IW-1:0] r_inh_cnt, w_inh_cnt_next;
  logic [TW-1:0] r_to_cnt, w_to_cnt_next;
  logic          r_clk_oe, w_clk_oe_next;
  logic          r_dat_oe, w_dat_oe_next;
  logic          w_tx_done, w_tx_error;
  logic          w_clk_filt, w_dat_sync, w_fall;
  logic          w_timed, w_timeout;
  logic [3:0]    w_bit_inc;

  ps2_line_sync #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_line_sync (
    .i_clk      (CLOCK_50),
    .i_srst     (reset),
    .i_ps2_clk  (ps2_clk_in),
    .i_ps2_dat  (ps2_dat_in),
    .o_clk_filt (w_clk_filt),
    .o_dat_sync (w_dat_sync),
    .o_fall     (w_fall)
  );

  assign w_timed   = (r_state == SEND) || (r_state == ACK) || (r_state == WAIT_IDLE);
  assign w_timeout = w_timed && (r_to_cnt == TO_LAST);
  assign w_bit_inc = r_bit_cnt + 4'd1;

  always_comb begin
    w_state_next   = r_state;
    w_data_next    = r_data;
    w_parity_next  = r_parity;
    w_bit_cnt_next = r_bit_cnt;
    w_inh_cnt_next = '0;
    w_to_cnt_next  = '0;
    w_clk_oe_next  = 1'b0;
    w_dat_oe_next  = 1'b0;
    w_tx_done      = 1'b0;
    w_tx_error     = 1'b0;
    if (w_timed) begin
      w_to_cnt_next = w_fall ? '0 : r_to_cnt + TW'(1);
    end
    case (r_state)
      IDLE: begin
        w_bit_cnt_next = '0;
        if (tx_valid) begin
          w_data_next   = tx_data;
          w_parity_next = odd_parity(tx_data);
          w_state_next  = INHIBIT;
          w_clk_oe_next = 1'b1;
        end
      end
      INHIBIT: begin
        w_clk_oe_next = 1'b1;
        if (r_inh_cnt == INH_LAST) begin
          w_state_next  = REQ;
          w_dat_oe_next = 1'b1;
        end else begin
          w_inh_cnt_next = r_inh_cnt + IW'(1);
        end
      end
      REQ: begin
        // Release CLK but keep the start bit on DAT.
        w_state_next  = SEND;
        w_dat_oe_next = 1'b1;
      end
      SEND: begin
        w_dat_oe_next = r_dat_oe;
        if (w_fall) begin
          w_bit_cnt_next = w_bit_inc;
          if (w_bit_inc <= 4'd8) begin
            w_dat_oe_next = ~r_data[r_bit_cnt[2:0]];
          end else if (w_bit_inc == 4'd9) begin
            w_dat_oe_next = ~r_parity;
          end else if (w_bit_inc == STOP_FALL) begin
            w_state_next = ACK;
          end
        end
      end
      ACK: begin
        if (w_fall) begin
          if (w_dat_sync) begin
            w_tx_error   = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (w_clk_filt && w_dat_sync) begin
          w_tx_done    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    // A stalled device wins over anything else happening this cycle.
    if (w_timeout) begin
      w_state_next   = IDLE;
      w_clk_oe_next  = 1'b0;
      w_dat_oe_next  = 1'b0;
      w_tx_done      = 1'b0;
      w_tx_error     = 1'b1;
      w_bit_cnt_next = '0;
      w_to_cnt_next  = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_inh_cnt <= '0;
      r_to_cnt  <= '0;
      r_clk_oe  <= 1'b0;
      r_dat_oe  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_inh_cnt <= w_inh_cnt_next;
      r_to_cnt  <= w_to_cnt_next;
      r_clk_oe  <= w_clk_oe_next;
      r_dat_oe  <= w_dat_oe_next;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    r_data   <= w_data_next;
    r_parity <= w_parity_next;
  end

  assign tx_ready   = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign tx_done    = w_tx_done;
  assign tx_error   = w_tx_error;
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset. It is the send-side counterpart of the existing PS/2 keyboard receive path and shares the same PS2_CLK/PS2_DAT lines. It drives the lines open-drain through output-enables and reports done or error per byte.

Parameters:
INHIBIT_CYCLES, 6000, cycles CLK is held low before the request (120 us at 50 MHz; protocol minimum is 100 us).
TIMEOUT_CYCLES, 750000, maximum cycles between device clock falling edges (15 ms) before abort.
FILTER_CYCLES, 8, cycles a synchronized PS2_CLK level must be stable before it is accepted.

Ports:
CLOCK_50  in  1  system clock, 50 MHz.
reset  in  1  synchronous, active-high.
tx_data  in  8  command byte.
tx_valid  in  1  request to send tx_data.
tx_ready  out  1  high in IDLE only.
tx_done  out  1  one-cycle pulse when the byte is acked and both lines are idle.
tx_error  out  1  one-cycle pulse on timeout or missing ack.
busy  out  1  high in any state other than IDLE.
ps2_clk_in  in  1  raw PS2_CLK level.
ps2_dat_in  in  1  raw PS2_DAT level.
ps2_clk_oe  out  1  1 = pull PS2_CLK low; 0 = release.
ps2_dat_oe  out  1  1 = pull PS2_DAT low; 0 = release.

Behaviour:
- Single clock domain: CLOCK_50, with synchronous active-high reset.
- Reset, including mid-frame:
  - On the next edge: state IDLE; ps2_clk_oe=0, ps2_dat_oe=0 (lines released); tx_done=0, tx_error=0, busy=0, tx_ready=1.
  - All counters are cleared; the shift register is don't-care.
- Input conditioning:
  - 2-FF synchronizer on both line inputs.
  - Clock filter: the filtered clock level changes only after the synchronized value has differed from it for FILTER_CYCLES consecutive cycles.
  - fall = filtered clock goes 1->0, as a one-cycle strobe.
- Accept handshake:
  - tx_valid & tx_ready in IDLE captures tx_data and parity = ~^tx_data (odd parity).
  - Next cycle: state INHIBIT, tx_ready=0.
  - tx_valid outside IDLE is ignored.
- States and transitions:
  - IDLE: both oe=0.
  - INHIBIT: clk_oe=1, dat_oe=0 for INHIBIT_CYCLES, then REQ.
  - REQ: one cycle with clk_oe=1 and dat_oe=1 (start bit 0), then SEND with clk_oe=0 and dat_oe held at 1.
  - SEND: falls counted by a 4-bit bit_cnt.
    - Falls 1..8: dat_oe = ~data[bit_cnt-1], LSB first.
    - Fall 9: dat_oe = ~parity.
    - Fall 10: dat_oe=0 (stop bit, line released).
    - Update takes effect the cycle after the fall strobe.
  - ACK: on fall 11, sample the synchronized DAT.
    - 0 -> WAIT_IDLE.
    - 1 -> tx_error pulse, go to IDLE.
  - WAIT_IDLE: when filtered clock = 1 and synchronized DAT = 1, pulse tx_done and go to IDLE.
- Timeout:
  - A counter runs in SEND, ACK and WAIT_IDLE and clears on every fall.
  - Reaching TIMEOUT_CYCLES forces both oe=0, pulses tx_error and goes to IDLE.
  - Timeout has priority over a fall in the same cycle.
- tx_done and tx_error are mutually exclusive. Each is exactly 1 cycle long, with tx_ready=1 in the following cycle.
- Never drive both oe=1 except during REQ.
- Never drive a line high; the pad logic applies oe ? 0 : Z.
- Back-to-back bytes: a new tx_valid may be accepted in the cycle after tx_done or tx_error.

Decomposition:
- Package ps2_pkg:
  - State enum: IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
  - Command constants: CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF.
  - Response constants: RSP_ACK=8'hFA, RSP_RESEND=8'hFE.
  - Parameter defaults.
- Sub-module ps2_line_sync:
  - Synchronizer, clock filter and fall-strobe generator.
  - To be reused by the receive path.

Test Plan:
1. Send 0xED with a device model that clocks at ~12 kHz, acks and releases:
   - Clock held low for 6000 cycles before the start bit.
   - Bits seen on rising edges: 0, 1,0,1,1,0,1,1,1, parity 1, stop 1.
   - tx_done pulses once; tx_ready returns to 1.
2. Send 0xF4 (five 1s): parity bit 0 on the line; tx_done pulses.
3. Device model withholds the ack (DAT high at fall 11): tx_error pulses, tx_done stays 0, both oe=0 the next cycle.
4. Device model stops clocking after fall 4: tx_error pulses exactly TIMEOUT_CYCLES after the last fall, and both lines are released.
5. Assert reset during fall 6 of a frame: next cycle both oe=0, busy=0, tx_ready=1. A new send of 0xFF then completes normally.
6. Inject 3-cycle glitches on PS2_CLK during SEND:
   - No extra bit is shifted; the frame for 0xED is still correct.
   - tx_valid pulsed while busy is ignored.
